// File: rtl/cat_rec_pkg.sv
// Shared definitions for the cat-recognition datapath: sequencer state
// encoding, control register location and default bus geometry.
package cat_rec_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_READ   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESULT = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Address 0 of the memory map is the control register; bit 0 is start.
   localparam int CTRL_ADDR = 0;
   localparam int START_BIT = 0;

   localparam int AMBA_WORD_DEF       = 24;
   localparam int AMBA_ADDR_DEPTH_DEF = 12;
   localparam int PIXEL_COUNT_DEF     = 3072;
   localparam int RD_LAT_DEF          = 1;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that re-times the memory read enable by the memory read
// latency, so the neuron calculator accumulates exactly when data is valid.
module valid_delay_line #(
   parameter int Depth = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic din,
   output logic dout,
   output logic tail_empty
);

   logic [Depth-1:0] stage_r;

   // Shift the valid bit one stage per cycle; a flush drops everything in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_r <= '0;
      end else if (flush) begin
         stage_r <= '0;
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < Depth; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   // Nothing is in flight except possibly the stage presenting at the output
   always_comb begin
      tail_empty = 1'b1;
      for (int i = 0; i < Depth - 1; i++) begin
         tail_empty = tail_empty & ~stage_r[i];
      end
   end

   assign dout = stage_r[Depth-1];

endmodule

// File: rtl/neuron_calc_sequencer.sv
// Sequences one inference: sweeps pixel/weight memories, streams valid
// pairs to the neuron calculator, then strobes the result. Owns the shared
// memory address port (APB address when idle, sweep address while busy).
module neuron_calc_sequencer
   import cat_rec_pkg::*;
#(
   parameter int Amba_Word       = AMBA_WORD_DEF,
   parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH_DEF,
   parameter int Pixel_Count     = PIXEL_COUNT_DEF,
   parameter int Rd_Lat          = RD_LAT_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [Amba_Addr_Depth-1:0] PADDR,
   input  logic                       apb_wr_en,
   output logic [Amba_Addr_Depth-1:0] mem_address,
   output logic                       mem_wr_en,
   output logic                       en_read,
   output logic                       calc_clear,
   output logic                       calc_en,
   output logic                       get_result,
   output logic                       busy,
   output logic                       done,
   output logic                       wr_reject
);

   // One spare bit so the largest legal pixel count never wraps the counter.
   localparam int CNT_W = Amba_Addr_Depth + 1;
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(Pixel_Count);
   localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(CTRL_ADDR + 1);

   if (Rd_Lat < 1 || Rd_Lat > 4) begin : g_bad_rd_lat
      $error("neuron_calc_sequencer: Rd_Lat must be 1..4");
   end
   if (Pixel_Count < 1 || Pixel_Count > (2**Amba_Addr_Depth) - 1) begin : g_bad_count
      $error("neuron_calc_sequencer: Pixel_Count out of address range");
   end
   if (START_BIT >= Amba_Word) begin : g_bad_start_bit
      $error("neuron_calc_sequencer: start bit outside control word");
   end

   state_t           state_r;
   logic [CNT_W-1:0] counter_r;
   logic             start_d_r;
   logic             live_r;
   logic             calc_clear_r;
   logic             en_read_r;
   logic             get_result_r;
   logic             busy_r;
   logic             done_r;

   logic             abort_s;
   logic             start_rise_s;
   logic             calc_en_s;
   logic             tail_empty_s;

   // start_d_r resets high so a start already asserted at reset release is not an edge
   assign start_rise_s = start & ~start_d_r;

   // A run in flight is abandoned as soon as start is withdrawn
   always_comb begin
      abort_s = 1'b0;
      case (state_r)
         ST_CLEAR, ST_READ, ST_DRAIN: abort_s = ~start;
         default:                     abort_s = 1'b0;
      endcase
   end

   // Sequencer FSM with sweep counter and registered control strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         counter_r    <= '0;
         start_d_r    <= 1'b1;
         live_r       <= 1'b0;
         calc_clear_r <= 1'b0;
         en_read_r    <= 1'b0;
         get_result_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         live_r       <= 1'b1;
         start_d_r    <= start;
         calc_clear_r <= 1'b0;
         get_result_r <= 1'b0;
         if (abort_s) begin
            state_r   <= ST_IDLE;
            counter_r <= '0;
            en_read_r <= 1'b0;
            busy_r    <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start_rise_s) begin
                     state_r      <= ST_CLEAR;
                     calc_clear_r <= 1'b1;
                     busy_r       <= 1'b1;
                  end
               end
               ST_CLEAR: begin
                  state_r   <= ST_READ;
                  counter_r <= FIRST_CNT;
                  en_read_r <= 1'b1;
               end
               ST_READ: begin
                  if (counter_r == LAST_CNT) begin
                     state_r   <= ST_DRAIN;
                     en_read_r <= 1'b0;
                  end else begin
                     counter_r <= counter_r + CNT_W'(1);
                  end
               end
               ST_DRAIN: begin
                  if (tail_empty_s) begin
                     state_r      <= ST_RESULT;
                     get_result_r <= 1'b1;
                  end
               end
               ST_RESULT: begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
               ST_DONE: begin
                  if (!start) begin
                     state_r   <= ST_IDLE;
                     counter_r <= '0;
                     done_r    <= 1'b0;
                  end
               end
               default: begin
                  state_r   <= ST_IDLE;
                  counter_r <= '0;
                  en_read_r <= 1'b0;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b0;
               end
            endcase
         end
      end
   end

   valid_delay_line #(
      .Depth(Rd_Lat)
   ) u_valid_delay_line (
      .clk        (clk),
      .rst        (rst),
      .flush      (abort_s),
      .din        (en_read_r),
      .dout       (calc_en_s),
      .tail_empty (tail_empty_s)
   );

   // APB pass-through must act in the same cycle, so the address mux and
   // write gating are combinational on registered state; live_r holds them
   // at 0 while in reset.
   assign mem_address = !live_r ? '0
                      : busy_r  ? counter_r[Amba_Addr_Depth-1:0]
                      :           PADDR;
   assign mem_wr_en   = live_r & apb_wr_en & ~busy_r;
   assign wr_reject   = apb_wr_en & busy_r;

   assign calc_clear  = calc_clear_r;
   assign en_read     = en_read_r;
   assign calc_en     = calc_en_s;
   assign get_result  = get_result_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule

// File: tb/tb_neuron_calc_sequencer.sv
// Directed bench: three sequencer instances (4/Rd_Lat1, 8/Rd_Lat1, 4095/Rd_Lat3)
// sharing clock, reset and APB inputs, each with its own start.
module tb_neuron_calc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] PADDR;
   logic        apb_wr_en;
   logic        start_a, start_c, start_b;

   logic [11:0] a_addr, c_addr, b_addr;
   logic a_wr, a_rd, a_clr, a_cen, a_gr, a_busy, a_done, a_rej;
   logic c_wr, c_rd, c_clr, c_cen, c_gr, c_busy, c_done, c_rej;
   logic b_wr, b_rd, b_clr, b_cen, b_gr, b_busy, b_done, b_rej;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   neuron_calc_sequencer #(.Amba_Word(24), .Amba_Addr_Depth(12), .Pixel_Count(4), .Rd_Lat(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .PADDR(PADDR), .apb_wr_en(apb_wr_en),
      .mem_address(a_addr), .mem_wr_en(a_wr), .en_read(a_rd), .calc_clear(a_clr), .calc_en(a_cen),
      .get_result(a_gr), .busy(a_busy), .done(a_done), .wr_reject(a_rej));

   neuron_calc_sequencer #(.Amba_Word(24), .Amba_Addr_Depth(12), .Pixel_Count(8), .Rd_Lat(1)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .PADDR(PADDR), .apb_wr_en(apb_wr_en),
      .mem_address(c_addr), .mem_wr_en(c_wr), .en_read(c_rd), .calc_clear(c_clr), .calc_en(c_cen),
      .get_result(c_gr), .busy(c_busy), .done(c_done), .wr_reject(c_rej));

   neuron_calc_sequencer #(.Amba_Word(24), .Amba_Addr_Depth(12), .Pixel_Count(4095), .Rd_Lat(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .PADDR(PADDR), .apb_wr_en(apb_wr_en),
      .mem_address(b_addr), .mem_wr_en(b_wr), .en_read(b_rd), .calc_clear(b_clr), .calc_en(b_cen),
      .get_result(b_gr), .busy(b_busy), .done(b_done), .wr_reject(b_rej));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a_quiet(input string tag);
      check_val({tag, " mem_address"}, 32'(a_addr), 32'd0);
      check_val({tag, " mem_wr_en"},   32'(a_wr),   32'd0);
      check_val({tag, " wr_reject"},   32'(a_rej),  32'd0);
      check_val({tag, " en_read"},     32'(a_rd),   32'd0);
      check_val({tag, " calc_clear"},  32'(a_clr),  32'd0);
      check_val({tag, " calc_en"},     32'(a_cen),  32'd0);
      check_val({tag, " get_result"},  32'(a_gr),   32'd0);
      check_val({tag, " busy"},        32'(a_busy), 32'd0);
      check_val({tag, " done"},        32'(a_done), 32'd0);
   endtask

   initial begin
      int saw_clr, saw_gr, saw_done, saw_busy;
      int first_en, n_en, n_rd, last_addr, addr0, gr_cyc, n_gr, last_en;

      // ---------------- reset state ----------------
      rst = 1'b0; start_a = 1'b0; start_c = 1'b0; start_b = 1'b0;
      PADDR = 12'd9; apb_wr_en = 1'b1;
      #12;
      check_a_quiet("reset");
      apb_wr_en = 1'b0; PADDR = 12'd7;
      #6 rst = 1'b1;
      repeat (3) tick();
      check_val("idle mem_address", 32'(a_addr), 32'd7);
      apb_wr_en = 1'b1; #1;
      check_val("idle mem_wr_en", 32'(a_wr), 32'd1);
      check_val("idle wr_reject", 32'(a_rej), 32'd0);
      apb_wr_en = 1'b0;

      // ---------------- tests 1 and 2: P=4, Rd_Lat=1 ----------------
      tick();
      start_a = 1'b1;                     // cycle 0
      for (int c = 1; c <= 12; c++) begin
         tick();
         apb_wr_en = (c == 3 || c == 10);
         PADDR     = (c == 3) ? 12'd5 : 12'd7;
         #1;
         check_val($sformatf("t1 c%0d calc_clear", c), 32'(a_clr),  32'(c == 1));
         check_val($sformatf("t1 c%0d en_read", c),    32'(a_rd),   32'(c >= 2 && c <= 5));
         check_val($sformatf("t1 c%0d calc_en", c),    32'(a_cen),  32'(c >= 3 && c <= 6));
         check_val($sformatf("t1 c%0d get_result", c), 32'(a_gr),   32'(c == 7));
         check_val($sformatf("t1 c%0d done", c),       32'(a_done), 32'(c >= 8));
         check_val($sformatf("t1 c%0d busy", c),       32'(a_busy), 32'(c >= 1 && c <= 7));
         check_val($sformatf("t1 c%0d mem_wr_en", c),  32'(a_wr),   32'(c == 10));
         check_val($sformatf("t1 c%0d wr_reject", c),  32'(a_rej),  32'(c == 3));
         if (c >= 2 && c <= 5)
            check_val($sformatf("t1 c%0d sweep addr", c), 32'(a_addr), 32'(c - 1));
         if (c >= 8)
            check_val($sformatf("t1 c%0d done addr", c), 32'(a_addr), 32'd7);
      end
      apb_wr_en = 1'b0;

      // ---------------- test 4: start held high after done ----------------
      saw_clr = 0; saw_done = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (a_clr)  saw_clr++;
         if (a_done) saw_done++;
      end
      check_val("t4 no restart clear", 32'(saw_clr), 32'd0);
      check_val("t4 done held", 32'(saw_done), 32'd20);
      start_a = 1'b0;
      tick();
      check_val("t4 done cleared", 32'(a_done), 32'd0);
      start_a = 1'b1;
      tick();
      check_val("t4 restart calc_clear", 32'(a_clr), 32'd1);
      check_val("t4 restart busy", 32'(a_busy), 32'd1);

      // ---------------- test 6: async reset mid-READ ----------------
      tick();
      tick();
      check_val("t6 pre en_read", 32'(a_rd), 32'd1);
      check_val("t6 pre addr", 32'(a_addr), 32'd2);
      #3 rst = 1'b0;
      apb_wr_en = 1'b1;
      #1;
      check_a_quiet("t6 in reset");
      apb_wr_en = 1'b0;
      #2 rst = 1'b1;
      saw_clr = 0; saw_busy = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (a_clr || a_rd)  saw_clr++;
         if (a_busy || a_gr) saw_busy++;
      end
      check_val("t6 no run after release", 32'(saw_clr), 32'd0);
      check_val("t6 stays idle", 32'(saw_busy), 32'd0);
      check_val("t6 idle addr", 32'(a_addr), 32'd7);
      start_a = 1'b0;

      // ---------------- test 3: abort at cycle 4 of P=8 ----------------
      repeat (3) tick();
      start_c = 1'b1;                     // cycle 0
      saw_gr = 0; saw_done = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 4) start_c = 1'b0;
         #1;
         if (c == 4) begin
            check_val("t3 c4 en_read", 32'(c_rd), 32'd1);
            check_val("t3 c4 addr", 32'(c_addr), 32'd3);
         end
         if (c == 5) begin
            check_val("t3 c5 en_read", 32'(c_rd), 32'd0);
            check_val("t3 c5 calc_en", 32'(c_cen), 32'd0);
            check_val("t3 c5 busy", 32'(c_busy), 32'd0);
         end
         if (c_gr)   saw_gr++;
         if (c_done) saw_done++;
      end
      check_val("t3 no get_result", 32'(saw_gr), 32'd0);
      check_val("t3 no done", 32'(saw_done), 32'd0);

      // ---------------- test 5: P=4095, Rd_Lat=3 ----------------
      tick();
      start_b = 1'b1;                     // cycle 0
      first_en = -1; n_en = 0; n_rd = 0; last_addr = -1; addr0 = 0;
      gr_cyc = -1; n_gr = 0; last_en = -1;
      for (int c = 1; c <= 4110; c++) begin
         tick();
         if (b_cen) begin
            if (first_en < 0) first_en = c;
            last_en = c;
            n_en++;
         end
         if (b_rd) begin
            n_rd++;
            last_addr = int'(b_addr);
            if (b_addr == 12'd0) addr0++;
         end
         if (b_gr) begin
            n_gr++;
            gr_cyc = c;
         end
      end
      check_val("t5 first calc_en", 32'(first_en), 32'd5);
      check_val("t5 last calc_en", 32'(last_en), 32'd4099);
      check_val("t5 calc_en count", 32'(n_en), 32'd4095);
      check_val("t5 en_read count", 32'(n_rd), 32'd4095);
      check_val("t5 last addr", 32'(last_addr), 32'd4095);
      check_val("t5 addr0 issued", 32'(addr0), 32'd0);
      check_val("t5 get_result count", 32'(n_gr), 32'd1);
      check_val("t5 get_result cycle", 32'(gr_cyc), 32'd4100);
      check_val("t5 done", 32'(b_done), 32'd1);
      start_b = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
